load_store_unit: RTL and testbench

Memory-access stage of the pipelined RV32I core. It sits directly upstream of the register file write port. It accepts one instruction per handshake from execute, performs loads and stores over a variable-latency data-memory bus, and stalls upstream while a transfer is outstanding. It drives `WE3`/`WD3`/`A3` with the loaded byte or half already shifted into the low bits; sign or zero extension is selected by the `WE3` code and done by the register file.

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: issues loads/stores on a variable-latency data bus and
// drives the register-file write port (WE3/WD3/A3) with single-cycle results.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  reg_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [4:0]            rd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [2:0]            WE3,
    output logic [DATA_WIDTH-1:0] WD3,
    output logic [4:0]            A3,
    output logic                  err
);

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
    // in_ready is high exactly while the FSM is IDLE.
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_n;
    logic                    req_n, we_n, err_n;
    logic [ADDR_WIDTH-1:0]   daddr_n;
    logic [3:0]              be_n;
    logic [DATA_WIDTH-1:0]   dwdata_n, wd3_n;
    logic [2:0]              we3_n;
    logic [4:0]              a3_n;
    logic [1:0]              addr_lo_q, addr_lo_n;
    logic [2:0]              funct3_q, funct3_n;
    logic [4:0]              rd_q, rd_n;
    logic                    is_load_q, is_load_n;

    logic                    is_mem, f3_legal, aligned, access_ok;
    logic [3:0]              store_be;
    logic [DATA_WIDTH-1:0]   store_data;
    logic [2:0]              load_code;

    assign in_ready = (state == IDLE);
    assign is_mem   = mem_read | mem_write;

    always_comb begin
        f3_legal = 1'b0;
        if (mem_write)
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);

        case (funct3[1:0])
            2'b01:   aligned = !addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        access_ok = f3_legal && aligned && !(mem_read && mem_write);

        case (funct3[1:0])
            2'b00: begin
                store_be   = 4'b0001 << addr[1:0];
                store_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                store_be   = addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = wdata;
            end
        endcase

        case (funct3_q)
            3'b000:  load_code = 3'b011;
            3'b001:  load_code = 3'b010;
            3'b010:  load_code = 3'b001;
            3'b100:  load_code = 3'b111;
            3'b101:  load_code = 3'b110;
            default: load_code = 3'b000;
        endcase
    end

    always_comb begin
        state_n   = state;
        req_n     = dmem_req;
        we_n      = dmem_we;
        daddr_n   = dmem_addr;
        be_n      = dmem_be;
        dwdata_n  = dmem_wdata;
        we3_n     = 3'b000;
        wd3_n     = WD3;
        a3_n      = A3;
        err_n     = 1'b0;
        addr_lo_n = addr_lo_q;
        funct3_n  = funct3_q;
        rd_n      = rd_q;
        is_load_n = is_load_q;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_mem) begin
                        if (access_ok) begin
                            state_n   = BUSY;
                            req_n     = 1'b1;
                            we_n      = mem_write;
                            daddr_n   = {addr[ADDR_WIDTH-1:2], 2'b00};
                            be_n      = mem_write ? store_be : 4'b0000;
                            dwdata_n  = mem_write ? store_data : '0;
                            addr_lo_n = addr[1:0];
                            funct3_n  = funct3;
                            rd_n      = rd;
                            is_load_n = mem_read;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (reg_write) begin
                        we3_n = (rd == 5'd0) ? 3'b000 : 3'b001;
                        wd3_n = addr;
                        a3_n  = rd;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    be_n    = 4'b0000;
                    if (is_load_q) begin
                        // x0 is not write-protected in the register file
                        we3_n = (rd_q == 5'd0) ? 3'b000 : load_code;
                        wd3_n = dmem_rdata >> {addr_lo_q, 3'b000};
                        a3_n  = rd_q;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            WE3        <= 3'b000;
            WD3        <= '0;
            A3         <= 5'd0;
            err        <= 1'b0;
            addr_lo_q  <= 2'b00;
            funct3_q   <= 3'b000;
            rd_q       <= 5'd0;
            is_load_q  <= 1'b0;
        end else begin
            state      <= state_n;
            dmem_req   <= req_n;
            dmem_we    <= we_n;
            dmem_addr  <= daddr_n;
            dmem_be    <= be_n;
            dmem_wdata <= dwdata_n;
            WE3        <= we3_n;
            WD3        <= wd3_n;
            A3         <= a3_n;
            err        <= err_n;
            addr_lo_q  <= addr_lo_n;
            funct3_q   <= funct3_n;
            rd_q       <= rd_n;
            is_load_q  <= is_load_n;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed loads, stores, errors,
// variable bus latency and reset during an outstanding transfer.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        mem_read, mem_write, reg_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [2:0]  WE3;
    logic [31:0] WD3;
    logic [4:0]  A3;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .WE3(WE3), .WD3(WD3), .A3(A3), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        rd        = 5'd0;
    endtask

    // drivers
    task automatic drive_op(input logic rd_en, input logic wr_en, input logic rw,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [4:0] r);
        in_valid  = 1'b1;
        mem_read  = rd_en;
        mem_write = wr_en;
        reg_write = rw;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        rd        = r;
        step();
        idle_inputs();
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] r, input logic [31:0] rdata, input int lat,
                           input logic [31:0] exp_addr, input logic [2:0] exp_we3,
                           input logic [31:0] exp_wd, input logic [31:0] mask);
        drive_op(1'b1, 1'b0, 1'b0, f3, a, 32'h0, r);
        for (int i = 0; i < lat; i++) begin
            check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
            check({tag, "_addr"}, dmem_addr, exp_addr);
            check({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_nowb"}, {29'd0, WE3}, 32'd0);
            if (i == 0) begin
                check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
                check({tag, "_be"}, {28'd0, dmem_be}, 32'd0);
            end
            if (i == lat - 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            step();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        check({tag, "_WE3"}, {29'd0, WE3}, {29'd0, exp_we3});
        if (exp_we3 != 3'b000) begin
            check({tag, "_WD3"}, WD3 & mask, exp_wd);
            check({tag, "_A3"}, {27'd0, A3}, {27'd0, r});
        end
        check({tag, "_rdy_wb"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_req_off"}, {31'd0, dmem_req}, 32'd0);
        step();
        check({tag, "_WE3_once"}, {29'd0, WE3}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        drive_op(1'b0, 1'b1, 1'b0, f3, a, wd, 5'd9);
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd1);
        check({tag, "_addr"}, dmem_addr, exp_addr);
        check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
        check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check({tag, "_WE3"}, {29'd0, WE3}, 32'd0);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_req_off"}, {31'd0, dmem_req}, 32'd0);
        step();
    endtask

    task automatic do_bad(input string tag, input logic rd_en, input logic wr_en,
                          input logic [2:0] f3, input logic [31:0] a);
        drive_op(rd_en, wr_en, 1'b0, f3, a, 32'h55, 5'd3);
        check({tag, "_err"}, {31'd0, err}, 32'd1);
        check({tag, "_WE3"}, {29'd0, WE3}, 32'd0);
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        step();
        check({tag, "_err_once"}, {31'd0, err}, 32'd0);
        check({tag, "_req2"}, {31'd0, dmem_req}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        step();
        step();
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_WE3", {29'd0, WE3}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_WD3", WD3, 32'd0);
        check("rst_A3", {27'd0, A3}, 32'd0);
        check("rst_daddr", dmem_addr, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        rst = 1'b0;
        step();

        // non-memory op
        drive_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h1234, 32'h0, 5'd5);
        check("alu_WE3", {29'd0, WE3}, 32'd1);
        check("alu_WD3", WD3, 32'h1234);
        check("alu_A3", {27'd0, A3}, 32'd5);
        check("alu_rdy", {31'd0, in_ready}, 32'd1);
        step();
        check("alu_WE3_once", {29'd0, WE3}, 32'd0);

        // loads, rdata 0x80FF7F01
        do_load("lb",  3'b000, 32'h103, 5'd1, 32'h80FF7F01, 1, 32'h100, 3'b011, 32'h80,       32'hFFFF_FFFF);
        do_load("lbu", 3'b100, 32'h101, 5'd2, 32'h80FF7F01, 1, 32'h100, 3'b111, 32'h7F,       32'h0000_00FF);
        do_load("lhu", 3'b101, 32'h102, 5'd3, 32'h80FF7F01, 2, 32'h100, 3'b110, 32'h80FF,     32'hFFFF_FFFF);
        do_load("lh",  3'b001, 32'h100, 5'd4, 32'h80FF7F01, 1, 32'h100, 3'b010, 32'h7F01,     32'h0000_FFFF);
        do_load("lw4", 3'b010, 32'h104, 5'd6, 32'h80FF7F01, 4, 32'h104, 3'b001, 32'h80FF7F01, 32'hFFFF_FFFF);
        do_load("ld_x0", 3'b010, 32'h100, 5'd0, 32'h12345678, 1, 32'h100, 3'b000, 32'h0,      32'hFFFF_FFFF);

        // stores
        do_store("sb", 3'b000, 32'h202, 32'h000000AB, 32'h200, 4'b0100, 32'hABABABAB);
        do_store("sh", 3'b001, 32'h202, 32'h1234CDEF, 32'h200, 4'b1100, 32'hCDEFCDEF);
        do_store("sw", 3'b010, 32'h204, 32'hDEADBEEF, 32'h204, 4'b1111, 32'hDEADBEEF);

        // ack while idle is ignored
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("idle_ack_WE3", {29'd0, WE3}, 32'd0);
        check("idle_ack_rdy", {31'd0, in_ready}, 32'd1);

        // errors
        do_bad("lw_mis",  1'b1, 1'b0, 3'b010, 32'h101);
        do_bad("lh_mis",  1'b1, 1'b0, 3'b001, 32'h003);
        do_bad("ld_f3",   1'b1, 1'b0, 3'b011, 32'h100);
        do_bad("st_f3",   1'b0, 1'b1, 3'b100, 32'h100);
        do_bad("rd_wr",   1'b1, 1'b1, 3'b010, 32'h100);

        // reset during BUSY, then a late ack
        drive_op(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 5'd7);
        check("rb_req", {31'd0, dmem_req}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        dmem_ack = 1'b1;
        check("rb_req_off", {31'd0, dmem_req}, 32'd0);
        check("rb_rdy", {31'd0, in_ready}, 32'd1);
        check("rb_addr", dmem_addr, 32'd0);
        step();
        dmem_ack = 1'b0;
        check("rb_WE3", {29'd0, WE3}, 32'd0);
        check("rb_req2", {31'd0, dmem_req}, 32'd0);
        check("rb_rdy2", {31'd0, in_ready}, 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
